std_spram_hs: RTL and testbench

STD_SPRAM_HS -- requirements
Module: std_spram_hs

---
 rtl/std_spram_pkg.sv | 18 +
 rtl/spram_be_array.sv | 53 +++++
 rtl/std_spram_hs.sv | 134 +++++++++++++
 tb/tb_std_spram_hs.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_spram_pkg.sv
// Shared state encoding and lane-mask helper for the std_spram_hs RAM block.
package std_spram_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_IDLE = 1'b1;

  localparam int MAX_BE_W = 128;

  // Expands a lane enable vector to the enable of one data bit.
  function automatic logic be_mask_bit(input logic [MAX_BE_W-1:0] be,
                                       input int bit_idx,
                                       input int lane_w);
    return be[7'(bit_idx / lane_w)];
  endfunction

endpackage

// File: rtl/spram_be_array.sv
// Single-port RAM with per-lane write enables and a registered (1-cycle) read.
module spram_be_array
  import std_spram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] dout
);

  localparam int LANE_W = DATA_W / BE_W;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef FPGA
  // Lane-sliced writes map directly onto block-RAM byte enables.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int l = 0; l < BE_W; l++)
          if (be[l]) mem[addr][l*LANE_W +: LANE_W] <= din[l*LANE_W +: LANE_W];
      end else begin
        dout <= mem[addr];
      end
    end
  end
`else
  logic [DATA_W-1:0] bit_mask;

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < DATA_W; i++)
      bit_mask[i] = be_mask_bit(MAX_BE_W'(be), i, LANE_W);
  end

  // dout only moves on reads so a pending read survives a following write.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= (mem[addr] & ~bit_mask) | (din & bit_mask);
      else    dout      <= mem[addr];
    end
  end
`endif

endmodule

// File: rtl/std_spram_hs.sv
// Handshaked single-port RAM: zero-fill FSM, credit-limited reads, 3-entry response FIFO.
module std_spram_hs
  import std_spram_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int DATA_W        = 32,
  parameter int BE_W          = 4,
  parameter bit INIT_ON_RESET = 1'b1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  output logic              init_busy
);

  state_t            state;
  logic [AW-1:0]     init_addr;
  logic              rd_inflight;
  logic              rd_oor;
  logic [1:0]        rsp_count;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [DATA_W-1:0] fifo_mem [3];

  logic              accept;
  logic              addr_ok;
  logic              rd_fire;
  logic              push;
  logic              pop;

  logic              ram_ce;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_dout;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits count buffered plus in-flight reads, so the FIFO can never overflow.
  assign req_ready = (state == ST_IDLE) &&
                     (({1'b0, rsp_count} + {2'b00, rd_inflight}) < 3'd3);
  assign init_busy = (state == ST_INIT);
  assign accept    = req_valid && req_ready;
  assign addr_ok   = ({1'b0, req_addr} < (AW+1)'(DEPTH));
  assign rd_fire   = accept && !req_we;
  assign push      = rd_inflight;
  assign rsp_valid = (rsp_count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_comb begin
    ram_ce   = accept && addr_ok;
    ram_we   = req_we;
    ram_addr = req_addr;
    ram_din  = req_wdata;
    ram_be   = req_be;
    if (state == ST_INIT) begin
      ram_ce   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = init_addr;
      ram_din  = '0;
      ram_be   = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
      init_addr <= '0;
    end else if (state == ST_INIT) begin
      if (init_addr == AW'(DEPTH - 1)) begin
        state     <= ST_IDLE;
        init_addr <= '0;
      end else begin
        init_addr <= init_addr + AW'(1);
      end
    end else if (init_start) begin
      state <= ST_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      rd_oor      <= 1'b0;
      rsp_count   <= 2'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
    end else begin
      rd_inflight <= rd_fire;
      rd_oor      <= rd_fire && !addr_ok;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   rsp_count <= rsp_count + 2'd1;
        2'b01:   rsp_count <= rsp_count - 2'd1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // Out-of-range reads never touched the array, so they capture zero instead.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rd_oor ? '0 : ram_dout;
  end

  spram_be_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .BE_W   (BE_W)
  ) u_array (
    .clk  (clk),
    .ce   (ram_ce),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .be   (ram_be),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_std_spram_hs.sv
// Bench for std_spram_hs: per-cycle comparison against a queue/array model plus directed literal checks.
module tb_std_spram_hs;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_we     = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata  = '0;
  logic [3:0]  req_be     = '0;
  logic        rsp_ready  = 1'b1;
  logic        init_start = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        init_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] model_mem [DEPTH];
  int          init_left = DEPTH;
  int          cyc       = 0;
  int          rsp_seen  = 0;
  logic [31:0] last_rsp  = '0;
  logic [31:0] rsp_or    = '0;
  bit          m_ready;
  bit          m_valid;

  always #5 clk = ~clk;

  std_spram_hs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .init_start (init_start),
    .init_busy  (init_busy)
  );

  function automatic void check_output(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endfunction

  // Model: a fill lasts DEPTH cycles, at most 3 reads outstanding, data 2 cycles after acceptance.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      cyc++;
      check_output("init_busy", 32'(init_busy), 32'(init_left != 0));
      m_ready = (init_left == 0) && (exp_q.size() < 3);
      check_output("req_ready", 32'(req_ready), 32'(m_ready));
      m_valid = (exp_q.size() > 0) && (cyc - exp_q[0].cyc >= 2);
      check_output("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check_output("rsp_rdata", rsp_rdata, exp_q[0].data);
        if (rsp_ready) begin
          last_rsp = rsp_rdata;
          rsp_or   = rsp_or | rsp_rdata;
          rsp_seen++;
          void'(exp_q.pop_front());
        end
      end
      if (req_valid && m_ready) begin
        if (req_we) begin
          for (int l = 0; l < 4; l++)
            if (req_be[l]) model_mem[req_addr][8*l +: 8] = req_wdata[8*l +: 8];
        end else begin
          exp_q.push_back('{model_mem[req_addr], cyc});
        end
      end
      if (init_left != 0) begin
        init_left--;
      end else if (init_start) begin
        init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end
    end
  end

  task automatic try_request(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, input logic init, input int max_cyc,
                             output bit acc);
    int n;
    n   = 0;
    acc = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_be     = be;
    init_start = init;
    while (!acc && n < max_cyc) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      init_start = 1'b0;
      n++;
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                                input logic [3:0] be, input logic init);
    bit acc;
    try_request(we, addr, wd, be, init, 100, acc);
    check_output("accept", 32'(acc), 32'd1);
  endtask

  task automatic go_idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_init_done();
    int n;
    n = 0;
    while (init_busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("init_done", 32'(init_busy), 32'd0);
  endtask

  task automatic count_busy(output int n);
    int k;
    n = 0;
    k = 0;
    do begin
      @(negedge clk);
      if (init_busy) n++;
      k++;
    end while (init_busy && k < 300);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int s;
    bit acc;

    repeat (3) @(negedge clk);
    check_output("rst_init_busy", 32'(init_busy), 32'd1);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy(n);
    check_output("init_len", 32'(n), 32'd64);

    // Whole array reads back as zero after the reset fill.
    s = rsp_seen;
    rsp_or = '0;
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, AW'(i), '0, 4'h0, 1'b0);
    go_idle();
    wait_drain();
    check_output("all_cnt", 32'(rsp_seen - s), 32'd64);
    check_output("all_zero", rsp_or, 32'h0);

    // Lane-masked write merge, then a be==0 write that must change nothing.
    apply_stimulus(1'b1, 6'd5, 32'hAABBCCDD, 4'hF, 1'b0);
    apply_stimulus(1'b1, 6'd5, 32'h11223344, 4'h5, 1'b0);
    apply_stimulus(1'b0, 6'd5, '0, 4'h0, 1'b0);
    go_idle();
    wait_drain();
    check_output("be_merge", last_rsp, 32'hAA22CC44);
    apply_stimulus(1'b1, 6'd5, 32'hFFFFFFFF, 4'h0, 1'b0);
    apply_stimulus(1'b0, 6'd5, '0, 4'h0, 1'b0);
    go_idle();
    wait_drain();
    check_output("be_zero", last_rsp, 32'hAA22CC44);

    // Read latency, then a 16-deep back-to-back stream.
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, AW'(i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0);
    apply_stimulus(1'b0, 6'd3, '0, 4'h0, 1'b0);
    go_idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check_output("rd_latency", 32'(n), 32'd2);
    check_output("rd_latency_data", rsp_rdata, 32'hC0DE0003);
    @(posedge clk);
    #1;
    wait_drain();
    s = rsp_seen;
    for (int i = 0; i < 16; i++) apply_stimulus(1'b0, AW'(i), '0, 4'h0, 1'b0);
    go_idle();
    wait_drain();
    check_output("stream_cnt", 32'(rsp_seen - s), 32'd16);
    check_output("stream_last", last_rsp, 32'hC0DE000F);

    // Credit limit with a stalled consumer, then drain in order.
    rsp_ready = 1'b0;
    s = rsp_seen;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, AW'(10 + i), '0, 4'h0, 1'b0);
    try_request(1'b0, 6'd13, '0, 4'h0, 1'b0, 5, acc);
    check_output("credit_stall", 32'(acc), 32'd0);
    check_output("ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    apply_stimulus(1'b0, 6'd13, '0, 4'h0, 1'b0);
    go_idle();
    wait_drain();
    check_output("drain_cnt", 32'(rsp_seen - s), 32'd4);
    check_output("drain_last", last_rsp, 32'hC0DE000D);

    // init_start coinciding with a read: old data returned, array cleared afterwards.
    apply_stimulus(1'b1, 6'd7, 32'h00001234, 4'hF, 1'b0);
    apply_stimulus(1'b0, 6'd7, '0, 4'h0, 1'b1);
    go_idle();
    wait_drain();
    check_output("pre_init_rd", last_rsp, 32'h00001234);
    check_output("init_started", 32'(init_busy), 32'd1);
    wait_init_done();
    apply_stimulus(1'b0, 6'd7, '0, 4'h0, 1'b0);
    go_idle();
    wait_drain();
    check_output("post_init_rd", last_rsp, 32'h0);

    // Reset in the middle of a fill restarts it with a full-length pass.
    apply_stimulus(1'b1, 6'd0, 32'hDEADBEEF, 4'hF, 1'b0);
    apply_stimulus(1'b1, 6'd63, 32'hCAFEF00D, 4'hF, 1'b0);
    apply_stimulus(1'b1, 6'd1, 32'h55555555, 4'hF, 1'b1);
    go_idle();
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("midrst_busy", 32'(init_busy), 32'd1);
    rst_n = 1'b1;
    count_busy(n);
    check_output("reinit_len", 32'(n), 32'd64);
    rsp_or = '0;
    apply_stimulus(1'b0, 6'd0, '0, 4'h0, 1'b0);
    apply_stimulus(1'b0, 6'd1, '0, 4'h0, 1'b0);
    apply_stimulus(1'b0, 6'd63, '0, 4'h0, 1'b0);
    go_idle();
    wait_drain();
    check_output("reinit_zero", rsp_or, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
